// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle for the s3 register bank port; the slave modport is the
// register bank's view and the master modport is the interconnect's view.
interface axil_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   s3_axi_awaddr;
  logic                    s3_axi_awvalid;
  logic                    s3_axi_awready;
  logic [DATA_WIDTH-1:0]   s3_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s3_axi_wstrb;
  logic                    s3_axi_wvalid;
  logic                    s3_axi_wready;
  logic [RESP_WIDTH-1:0]   s3_axi_bresp;
  logic                    s3_axi_bvalid;
  logic                    s3_axi_bready;
  logic [ADDR_WIDTH-1:0]   s3_axi_araddr;
  logic                    s3_axi_arvalid;
  logic                    s3_axi_arready;
  logic [DATA_WIDTH-1:0]   s3_axi_rdata;
  logic [RESP_WIDTH-1:0]   s3_axi_rresp;
  logic                    s3_axi_rvalid;
  logic                    s3_axi_rready;

  modport master (
    output s3_axi_awaddr, s3_axi_awvalid, s3_axi_wdata, s3_axi_wstrb, s3_axi_wvalid,
           s3_axi_bready, s3_axi_araddr, s3_axi_arvalid, s3_axi_rready,
    input  s3_axi_awready, s3_axi_wready, s3_axi_bresp, s3_axi_bvalid,
           s3_axi_arready, s3_axi_rdata, s3_axi_rresp, s3_axi_rvalid
  );

  modport slave (
    input  s3_axi_awaddr, s3_axi_awvalid, s3_axi_wdata, s3_axi_wstrb, s3_axi_wvalid,
           s3_axi_bready, s3_axi_araddr, s3_axi_arvalid, s3_axi_rready,
    output s3_axi_awready, s3_axi_wready, s3_axi_bresp, s3_axi_bvalid,
           s3_axi_arready, s3_axi_rdata, s3_axi_rresp, s3_axi_rvalid
  );
endinterface

// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank with independent AW/W capture, SLVERR decode,
// read-only status slots and per-register write pulses. Define AXIL_WSTRB_EN for byte-lane writes.
module axil_regbank #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   RESP_WIDTH = 3,
  parameter int                   NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           s3_axi_aclk,
  input  logic                           s3_axi_areset,
  axil_regbank_if.slave                  axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - OFF_BITS;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_RESP } r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] eff_data;
  logic [STRB_WIDTH-1:0] eff_strb;
  logic [IDX_WIDTH-1:0]  w_idx, r_idx;
  logic [NUM_REGS-1:0]   w_hit, r_hit;
  logic                  w_err, r_err;
  logic [DATA_WIDTH-1:0] r_data_next;

  // Handshakes depend only on registered state so ready never combinationally follows valid.
  assign aw_hs  = axi.s3_axi_awvalid && (w_state == W_IDLE) && !aw_held;
  assign w_hs   = axi.s3_axi_wvalid  && (w_state == W_IDLE) && !w_held;
  assign ar_hs  = axi.s3_axi_arvalid && (r_state == R_IDLE);
  assign commit = (aw_hs && (w_hs || w_held)) || (w_hs && aw_held);

  assign eff_addr = aw_held ? aw_addr_q : axi.s3_axi_awaddr;
  assign eff_data = w_held  ? w_data_q  : axi.s3_axi_wdata;
  assign eff_strb = w_held  ? w_strb_q  : axi.s3_axi_wstrb;
  assign w_idx    = eff_addr[ADDR_WIDTH-1:OFF_BITS];
  assign r_idx    = axi.s3_axi_araddr[ADDR_WIDTH-1:OFF_BITS];

  always_comb begin
    w_hit       = '0;
    r_hit       = '0;
    r_data_next = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_WIDTH'(i)) w_hit[i] = 1'b1;
      if (r_idx == IDX_WIDTH'(i)) r_hit[i] = 1'b1;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_hit[i]) r_data_next = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
    end
    w_err = !(|w_hit) || |(w_hit & RO_MASK);
    r_err = !(|r_hit);
  end

  always_ff @(posedge s3_axi_aclk) begin
    if (s3_axi_areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_next;
      r_state <= r_state_next;
    end
  end

  always_comb begin
    w_state_next       = w_state;
    axi.s3_axi_awready = 1'b0;
    axi.s3_axi_wready  = 1'b0;
    axi.s3_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi.s3_axi_awready = !aw_held;
        axi.s3_axi_wready  = !w_held;
        if (commit) w_state_next = W_RESP;
      end
      W_RESP: begin
        axi.s3_axi_bvalid = 1'b1;
        if (axi.s3_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next       = r_state;
    axi.s3_axi_arready = 1'b0;
    axi.s3_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi.s3_axi_arready = 1'b1;
        if (ar_hs) r_state_next = R_RESP;
      end
      R_RESP: begin
        axi.s3_axi_rvalid = 1'b1;
        if (axi.s3_axi_rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // A lone AW or W beat is parked here until its partner arrives.
  always_ff @(posedge s3_axi_aclk) begin
    if (s3_axi_areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axi.s3_axi_awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= axi.s3_axi_wdata;
        w_strb_q <= axi.s3_axi_wstrb;
      end
    end
  end

  always_ff @(posedge s3_axi_aclk) begin
    if (s3_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse      <= '0;
      axi.s3_axi_bresp  <= '0;
    end else begin
      reg_wr_pulse <= (commit && !w_err) ? w_hit : '0;
      if (commit) axi.s3_axi_bresp <= w_err ? RESP_SLVERR : RESP_OKAY;
      if (commit && !w_err) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_hit[i]) begin
`ifdef AXIL_WSTRB_EN
            for (int k = 0; k < STRB_WIDTH; k++) begin
              if (eff_strb[k]) regs[i][8*k +: 8] <= eff_data[8*k +: 8];
            end
`else
            regs[i] <= eff_data;
`endif
          end
        end
      end
    end
  end

  // Read data is captured at the AR handshake, so a same-edge write is not yet visible.
  always_ff @(posedge s3_axi_aclk) begin
    if (s3_axi_areset) begin
      axi.s3_axi_rdata <= '0;
      axi.s3_axi_rresp <= '0;
    end else if (ar_hs) begin
      axi.s3_axi_rdata <= r_data_next;
      axi.s3_axi_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  logic unused_bits;
`ifdef AXIL_WSTRB_EN
  assign unused_bits = ^{eff_addr[OFF_BITS-1:0], axi.s3_axi_araddr[OFF_BITS-1:0], status_in};
`else
  assign unused_bits = ^{eff_addr[OFF_BITS-1:0], axi.s3_axi_araddr[OFF_BITS-1:0], status_in, eff_strb};
`endif
endmodule

// File: tb/tb_axil_regbank.sv
// Randomised bench for axil_regbank: a transaction-level model of the register map is
// checked against every DUT output each cycle, plus directed literal checks.
module tb_axil_regbank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0008;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) bus ();
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] status_in;
  logic [NR-1:0]    reg_wr_pulse;

  axil_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .s3_axi_aclk   (clk),
    .s3_axi_areset (rst),
    .axi           (bus),
    .reg_out       (reg_out),
    .status_in     (status_in),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: register map as an array, bus channels as simple pending flags.
  logic [DW-1:0] m_regs [NR];
  bit            m_aw_have, m_w_have, m_bvalid, m_rvalid, model_valid;
  logic [AW-1:0] m_aw_addr;
  logic [DW-1:0] m_w_data, m_rdata;
  logic [3:0]    m_w_strb;
  logic [RW-1:0] m_bresp, m_rresp;
  logic [NR-1:0] m_pulse;

  initial model_valid = 0;

  always @(negedge clk) begin : compare_and_step
    bit aw_fire, w_fire, ar_fire;
    int idx;
    if (model_valid) begin
      checkOutput("awready", bus.s3_axi_awready, !m_bvalid && !m_aw_have);
      checkOutput("wready",  bus.s3_axi_wready,  !m_bvalid && !m_w_have);
      checkOutput("arready", bus.s3_axi_arready, !m_rvalid);
      checkOutput("bvalid",  bus.s3_axi_bvalid,  m_bvalid);
      checkOutput("bresp",   bus.s3_axi_bresp,   m_bresp);
      checkOutput("rvalid",  bus.s3_axi_rvalid,  m_rvalid);
      checkOutput("rdata",   bus.s3_axi_rdata,   m_rdata);
      checkOutput("rresp",   bus.s3_axi_rresp,   m_rresp);
      checkOutput("reg_wr_pulse", reg_wr_pulse, m_pulse);
      for (int i = 0; i < NR; i++)
        checkOutput($sformatf("reg_out[%0d]", i), reg_out[i*DW +: DW], m_regs[i]);
    end
    // Advance the model to the state the DUT holds after the coming rising edge.
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_aw_have = 0; m_w_have = 0; m_bvalid = 0; m_rvalid = 0;
      m_aw_addr = '0; m_w_data = '0; m_w_strb = '0;
      m_bresp = '0; m_rresp = '0; m_rdata = '0; m_pulse = '0;
      model_valid = 1;
    end else if (model_valid) begin
      aw_fire = bus.s3_axi_awvalid && !m_bvalid && !m_aw_have;
      w_fire  = bus.s3_axi_wvalid  && !m_bvalid && !m_w_have;
      ar_fire = bus.s3_axi_arvalid && !m_rvalid;
      if (m_rvalid) begin
        if (bus.s3_axi_rready) m_rvalid = 0;
      end else if (ar_fire) begin
        idx = int'(bus.s3_axi_araddr) / 4;
        m_rvalid = 1;
        if (idx >= NR) begin
          m_rdata = '0; m_rresp = 3'd2;
        end else begin
          m_rdata = RO[idx] ? status_in[idx*DW +: DW] : m_regs[idx];
          m_rresp = 3'd0;
        end
      end
      m_pulse = '0;
      if (m_bvalid) begin
        if (bus.s3_axi_bready) m_bvalid = 0;
      end else begin
        if (aw_fire) begin m_aw_have = 1; m_aw_addr = bus.s3_axi_awaddr; end
        if (w_fire) begin m_w_have = 1; m_w_data = bus.s3_axi_wdata; m_w_strb = bus.s3_axi_wstrb; end
        if (m_aw_have && m_w_have) begin
          idx = int'(m_aw_addr) / 4;
          m_aw_have = 0; m_w_have = 0; m_bvalid = 1;
          if (idx >= NR) m_bresp = 3'd2;
          else if (RO[idx]) m_bresp = 3'd2;
          else begin
            m_bresp = 3'd0;
            m_pulse[idx] = 1'b1;
`ifdef AXIL_WSTRB_EN
            for (int k = 0; k < 4; k++)
              if (m_w_strb[k]) m_regs[idx][8*k +: 8] = m_w_data[8*k +: 8];
`else
            m_regs[idx] = m_w_data;
`endif
          end
        end
      end
    end
  end

  // Drives one write with per-channel start cycles; reports B latency, pulses seen and response.
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_at, input int w_at, input int b_at,
                               output int b_lat, output int pulses, output logic [2:0] resp);
    int cyc = 0;
    int commit_cyc = -1;
    bit aw_done = 0, w_done = 0, b_done = 0;
    b_lat = -1; pulses = 0; resp = 3'd7;
    while (!b_done && cyc < 64) begin
      bus.s3_axi_awvalid = !aw_done && (cyc >= aw_at);
      bus.s3_axi_awaddr  = addr;
      bus.s3_axi_wvalid  = !w_done && (cyc >= w_at);
      bus.s3_axi_wdata   = data;
      bus.s3_axi_wstrb   = strb;
      bus.s3_axi_bready  = (cyc >= b_at);
      @(negedge clk);
      pulses += $countones(reg_wr_pulse);
      if (bus.s3_axi_bvalid && b_lat < 0 && commit_cyc >= 0) b_lat = cyc - commit_cyc;
      if (bus.s3_axi_bvalid && bus.s3_axi_bready) begin b_done = 1; resp = bus.s3_axi_bresp; end
      if (bus.s3_axi_awvalid && bus.s3_axi_awready) aw_done = 1;
      if (bus.s3_axi_wvalid && bus.s3_axi_wready) w_done = 1;
      if (aw_done && w_done && commit_cyc < 0) commit_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    bus.s3_axi_awvalid = 0; bus.s3_axi_wvalid = 0; bus.s3_axi_bready = 0;
    checkOutput("write_done", b_done, 1);
  endtask

  task automatic axiRead(input logic [7:0] addr, input int r_at, output logic [31:0] data, output logic [2:0] resp);
    int cyc = 0;
    bit ar_done = 0, r_done = 0;
    data = '0; resp = 3'd7;
    while (!r_done && cyc < 64) begin
      bus.s3_axi_arvalid = !ar_done;
      bus.s3_axi_araddr  = addr;
      bus.s3_axi_rready  = (cyc >= r_at);
      @(negedge clk);
      if (bus.s3_axi_rvalid && bus.s3_axi_rready) begin r_done = 1; data = bus.s3_axi_rdata; resp = bus.s3_axi_rresp; end
      if (bus.s3_axi_arvalid && bus.s3_axi_arready) ar_done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.s3_axi_arvalid = 0; bus.s3_axi_rready = 0;
    checkOutput("read_done", r_done, 1);
  endtask

  task automatic pulseReset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    int b_lat, pulses;
    logic [2:0] resp, rresp;
    logic [31:0] rdata, exp_strb;
    logic [7:0] a0, a1;

    rst = 1;
    bus.s3_axi_awaddr = '0; bus.s3_axi_awvalid = 0; bus.s3_axi_wdata = '0; bus.s3_axi_wstrb = '0;
    bus.s3_axi_wvalid = 0; bus.s3_axi_bready = 0; bus.s3_axi_araddr = '0; bus.s3_axi_arvalid = 0;
    bus.s3_axi_rready = 0;
    for (int i = 0; i < NR; i++) status_in[i*DW +: DW] = 32'h5000_0000 + i;
    status_in[3*DW +: DW] = 32'h0000_CAFE;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    checkOutput("reset_ready", {bus.s3_axi_awready, bus.s3_axi_wready, bus.s3_axi_arready}, 3'b111);
    checkOutput("reset_valid", {bus.s3_axi_bvalid, bus.s3_axi_rvalid}, 2'b00);
    @(posedge clk); #1;

    applyStimulus(8'h00, 32'd25, 4'hF, 0, 0, 0, b_lat, pulses, resp);
    checkOutput("t1_blat", b_lat, 1);
    checkOutput("t1_bresp", resp, 0);
    checkOutput("t1_pulses", pulses, 1);
    checkOutput("t1_slot0", reg_out[0 +: 32], 32'd25);

    applyStimulus(8'h04, 32'd34, 4'hF, 0, 3, 8, b_lat, pulses, resp);
    checkOutput("t2_blat", b_lat, 1);
    checkOutput("t2_bresp", resp, 0);
    checkOutput("t2_slot1", reg_out[32 +: 32], 32'd34);

    applyStimulus(8'h08, 32'h1122_3344, 4'hF, 0, 0, 0, b_lat, pulses, resp);
    applyStimulus(8'h08, 32'hAABB_CCDD, 4'h5, 1, 0, 0, b_lat, pulses, resp);
    axiRead(8'h08, 0, rdata, rresp);
`ifdef AXIL_WSTRB_EN
    exp_strb = 32'h11BB_33DD;
`else
    exp_strb = 32'hAABB_CCDD;
`endif
    checkOutput("t3_rdata", rdata, exp_strb);
    checkOutput("t3_rresp", rresp, 0);

    axiRead(8'h40, 2, rdata, rresp);
    checkOutput("t4_rdata", rdata, 0);
    checkOutput("t4_rresp", rresp, 2);
    applyStimulus(8'h40, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, b_lat, pulses, resp);
    checkOutput("t4_bresp", resp, 2);
    checkOutput("t4_pulses", pulses, 0);
    checkOutput("t4_slot0", reg_out[0 +: 32], 32'd25);

    axiRead(8'h0C, 0, rdata, rresp);
    checkOutput("t5_rdata", rdata, 32'h0000_CAFE);
    checkOutput("t5_rresp", rresp, 0);
    applyStimulus(8'h0C, 32'h1234, 4'hF, 0, 0, 1, b_lat, pulses, resp);
    checkOutput("t5_bresp", resp, 2);
    checkOutput("t5_pulses", pulses, 0);
    checkOutput("t5_slot3", reg_out[96 +: 32], 32'd0);

    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      a0 = 8'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      a1 = (kind == 2 && $urandom_range(0, 1) == 1) ? a0 : 8'($urandom_range(0, 19) * 4);
      if (kind == 0) begin
        applyStimulus(a0, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 4), b_lat, pulses, resp);
      end else if (kind == 1) begin
        axiRead(a0, $urandom_range(0, 3), rdata, rresp);
      end else begin
        fork
          applyStimulus(a0, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                        $urandom_range(0, 3), b_lat, pulses, resp);
          axiRead(a1, $urandom_range(0, 3), rdata, rresp);
        join
      end
    end

    bus.s3_axi_arvalid = 1; bus.s3_axi_araddr = 8'h00;
    bus.s3_axi_awvalid = 1; bus.s3_axi_awaddr = 8'h10;
    @(posedge clk); #1;
    bus.s3_axi_arvalid = 0; bus.s3_axi_awvalid = 0;
    @(negedge clk);
    checkOutput("t6_pre_rvalid", bus.s3_axi_rvalid, 1);
    checkOutput("t6_pre_awready", bus.s3_axi_awready, 0);
    @(posedge clk); #1;
    pulseReset();
    @(negedge clk);
    checkOutput("t6_valids", {bus.s3_axi_rvalid, bus.s3_axi_bvalid}, 2'b00);
    checkOutput("t6_readies", {bus.s3_axi_awready, bus.s3_axi_wready, bus.s3_axi_arready}, 3'b111);
    @(posedge clk); #1;
    bus.s3_axi_wvalid = 1; bus.s3_axi_wdata = 32'h77; bus.s3_axi_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.s3_axi_wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t6_no_bvalid", bus.s3_axi_bvalid, 0);
      checkOutput("t6_no_pulse", reg_wr_pulse, 0);
      checkOutput("t6_slot4", reg_out[128 +: 32], 32'd0);
    end
    @(posedge clk); #1;
    pulseReset();
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
